// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
// Serialises bytes onto a UART line, LSB first: 8N1 framing by default, or 8E1
// when UART_TX_PARITY_EN is defined. The baud rate is fixed at elaboration as
// INPUT_CLOCK_FREQ / BAUD_RATE (truncating). That quotient must be at least 2.
//
// A one-entry holding register sits in front of the shift register. A producer
// can therefore queue the next byte while the current frame is on the wire, and
// back-to-back frames go out with no idle gap between them.
//
// Optional feature macro: UART_TX_PARITY_EN
//    defined   : an even-parity bit follows data bit 7 (11-bit frame)
//    undefined : no parity state and no parity logic (10-bit frame)
//
// Ports
//    clk_in        system clock, all logic on the rising edge
//    rst_in        synchronous active-high reset
//    data_byte_in  byte to send, sampled only on an accepting edge
//    trigger_in    producer valid; accepted when trigger_in && ready_out
//    ready_out     holding register empty
//    busy_out      frame in progress or byte queued
//    tx_wire_out   registered serial line, idles high
// ----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int INPUT_CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE        = 460800
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_byte_in,
   input  logic       trigger_in,
   output logic       ready_out,
   output logic       busy_out,
   output logic       tx_wire_out
);

   // state    | meaning
   // ---------+--------------------------------------------------
   // S_IDLE   | line high, waiting for the holding register
   // S_START  | start bit (low)
   // S_DATA   | eight data bits, LSB first
   // S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
   // S_STOP   | stop bit (high); may chain straight into S_START

   localparam int UART_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W           = $clog2(UART_BIT_PERIOD) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_BIT_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           r_state;
   logic [7:0]       r_hold_data;
   logic             r_hold_valid;
   logic [7:0]       r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             r_tx;
`ifdef UART_TX_PARITY_EN
   logic             r_parity;
`endif

   logic w_accept;
   logic w_bit_end;

   assign w_accept  = trigger_in && !r_hold_valid;
   assign w_bit_end = (r_cnt == CNT_LAST);

   assign ready_out   = !r_hold_valid;
   assign busy_out    = (r_state != S_IDLE) || r_hold_valid;
   assign tx_wire_out = r_tx;

   // The FSM only consumes the holding register while r_hold_valid=1. An
   // accept only happens while it is 0. The set and the clear below can
   // therefore never fire on the same edge.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= S_IDLE;
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
         r_shift      <= '0;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity     <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_hold_data  <= data_byte_in;
            r_hold_valid <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (r_hold_valid) begin
                  r_shift      <= r_hold_data;
`ifdef UART_TX_PARITY_EN
                  r_parity     <= ^r_hold_data;
`endif
                  r_hold_valid <= 1'b0;
                  r_cnt        <= '0;
                  r_idx        <= '0;
                  r_tx         <= 1'b0;
                  r_state      <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     // The next data bit is the one that shifts into position 0.
                     r_tx <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`endif

            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_hold_valid) begin
                     // Chain straight into the next start bit, with no idle gap.
                     r_shift      <= r_hold_data;
`ifdef UART_TX_PARITY_EN
                     r_parity     <= ^r_hold_data;
`endif
                     r_hold_valid <= 1'b0;
                     r_idx        <= '0;
                     r_tx         <= 1'b0;
                     r_state      <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_tx    <= 1'b1;
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

   localparam int P = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * P;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] data_byte_in = 8'h00;
   logic       trigger_in = 1'b0;
   logic       ready_out;
   logic       busy_out;
   logic       tx_wire_out;

   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   logic abort = 1'b0;
   logic [7:0] exp_q[$];
   int   starts[$];

   uart_transmitter #(
      .INPUT_CLOCK_FREQ(1_000_000),
      .BAUD_RATE       (100_000)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .data_byte_in(data_byte_in),
      .trigger_in  (trigger_in),
      .ready_out   (ready_out),
      .busy_out    (busy_out),
      .tx_wire_out (tx_wire_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      nchk++;
      if (got !== expv) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // Reference frame, written as it appears on the line: bit 0 = start,
   // then the data bits LSB first, then the optional parity bit, then the stop bit.
   function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
      logic [NB-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      begin
         int ones;
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(b[i]);
         f[9] = (ones % 2) == 1;
      end
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // Monitor: decodes every frame seen on the line and checks it against the
   // scoreboard queue.
   initial begin : monitor
      logic [NB-1:0] bits;
      logic          stable;
      logic          aborted;
      logic [7:0]    eb;
      forever begin
         @(negedge clk_in);
         if (!abort && !rst_in && tx_wire_out === 1'b0) begin
            starts.push_back(cyc);
            bits = '0;
            stable = 1'b1;
            aborted = 1'b0;
            for (int k = 0; k < NB * P; k++) begin
               if (k != 0) @(negedge clk_in);
               if (abort) begin
                  aborted = 1'b1;
                  break;
               end
               if (k % P == 0) bits[k/P] = tx_wire_out;
               else if (tx_wire_out !== bits[k/P]) stable = 1'b0;
            end
            if (aborted) begin
               exp_q.delete();
            end else begin
               check("bit_stable", stable, 1);
               check("frame_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  eb = exp_q.pop_front();
                  check("frame_bits", bits, frame_of(eb));
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, output int e0);
      int w;
      w = 0;
      @(negedge clk_in);
      while (!ready_out && w < 2000) begin
         @(negedge clk_in);
         w++;
      end
      check("send_ready", ready_out, 1);
      data_byte_in = b;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      e0 = cyc;
      trigger_in = 1'b0;
      exp_q.push_back(b);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk_in);
      while (busy_out && w < 3000) begin
         @(negedge clk_in);
         w++;
      end
      check("idle_reached", busy_out, 0);
   endtask

   // A single byte sent from an idle line: check the handshake, the start
   // latency and the total frame length.
   task automatic single_byte(input logic [7:0] b);
      int e0, n0, w;
      n0 = starts.size();
      send(b, e0);
      @(negedge clk_in);
      check("ready_low_after_accept", ready_out, 0);
      check("busy_after_accept", busy_out, 1);
      @(negedge clk_in);
      check("ready_back_after_load", ready_out, 1);
      check("start_bit_low", tx_wire_out, 0);
      w = 0;
      while (starts.size() <= n0 && w < 20) begin
         @(negedge clk_in);
         w++;
      end
      check("start_seen", starts.size() > n0, 1);
      if (starts.size() > n0) check("start_latency", starts[n0], e0 + 1);
      w = 0;
      while (busy_out && w < 300) begin
         @(negedge clk_in);
         w++;
      end
      check("busy_fall_cycle", cyc, e0 + 1 + FRAME);
   endtask

   initial begin : stim
      int e0, e1, n0, w, lows, tgt;
      logic [7:0] rb;

      // Reset held with trigger asserted: nothing may be captured.
      rst_in = 1'b1;
      trigger_in = 1'b1;
      data_byte_in = 8'h99;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_tx", tx_wire_out, 1);
      check("rst_ready", ready_out, 1);
      check("rst_busy", busy_out, 0);
      trigger_in = 1'b0;
      rst_in = 1'b0;
      repeat (30) @(negedge clk_in);
      check("rst_no_frame", starts.size(), 0);
      check("rst_still_idle", busy_out, 0);

      // A single byte, then the byte used for the parity check.
      single_byte(8'hA5);
      wait_idle();
      single_byte(8'h07);
      wait_idle();

      // Back-to-back frames: the second byte is queued while the first is in DATA.
      n0 = starts.size();
      send(8'h00, e0);
      repeat (30) @(negedge clk_in);
      send(8'hFF, e1);
      w = 0;
      while (starts.size() < n0 + 2 && w < 400) begin
         @(negedge clk_in);
         w++;
      end
      check("b2b_two_starts", starts.size() >= n0 + 2, 1);
      if (starts.size() >= n0 + 2) check("b2b_gap", starts[n0+1] - starts[n0], FRAME);
      wait_idle();

      // Backpressure: while the holding register is full, 0x11 must be ignored.
      send(8'h33, e0);
      send(8'h44, e1);
      @(negedge clk_in);
      check("bp_ready_low", ready_out, 0);
      trigger_in = 1'b1;
      data_byte_in = 8'h11;
      repeat (20) @(negedge clk_in);
      data_byte_in = 8'h22;
      w = 0;
      while (!ready_out && w < 400) begin
         @(negedge clk_in);
         w++;
      end
      check("bp_ready_rise_cycle", cyc, e0 + 1 + FRAME);
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      exp_q.push_back(8'h22);
      wait_idle();

      // Reset during data bit 3 of 0x3C, with 0x55 queued behind it.
      send(8'h3C, e0);
      send(8'h55, e1);
      tgt = e0 + 1 + P + 3 * P + 5;
      w = 0;
      while (cyc < tgt && w < 200) begin
         @(negedge clk_in);
         w++;
      end
      abort = 1'b1;
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      check("midrst_tx", tx_wire_out, 1);
      check("midrst_ready", ready_out, 1);
      check("midrst_busy", busy_out, 0);
      @(negedge clk_in);
      abort = 1'b0;
      n0 = starts.size();
      lows = 0;
      repeat (250) begin
         @(negedge clk_in);
         if (tx_wire_out !== 1'b1) lows++;
      end
      check("midrst_line_quiet", lows, 0);
      check("midrst_no_frames", starts.size(), n0);

      // Randomised bytes with random gaps; some sends land mid-frame and queue.
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 120)) @(negedge clk_in);
         rb = 8'($urandom_range(0, 255));
         send(rb, e0);
      end
      wait_idle();
      repeat (P) @(negedge clk_in);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serializes bytes onto a single UART line: 8N1 framing (8E1 when parity is compiled in), LSB first, with a fixed baud rate derived from the system clock. It is the transmit counterpart of the design's UART receiver and drives the host-facing TX pin. A one-entry holding register sits in front of the shift register, so a producer can queue the next byte while the current frame is on the wire. This allows gap-free back-to-back frames.

## Interface
- INPUT_CLOCK_FREQ, 100_000_000, clk_in frequency in Hz
- BAUD_RATE, 460800, line rate in bits/s
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- data_byte_in  input  8  byte to send; sampled only on an accepting edge
- trigger_in  input  1  producer valid; byte accepted on a rising edge where trigger_in && ready_out
- ready_out  output  1  holding register empty; can accept a byte this cycle
- busy_out  output  1  frame in progress or byte queued
- tx_wire_out  output  1  serial line, idles high; registered output

## Operation
- UART_BIT_PERIOD = INPUT_CLOCK_FREQ/BAUD_RATE, using integer (truncating) division. Requirement: UART_BIT_PERIOD >= 2.
- Bit counter width: $clog2(UART_BIT_PERIOD)+1. It counts 0..UART_BIT_PERIOD-1 and then wraps to 0.
- Holding register: hold_data[7:0] and hold_valid.
  - An accepting edge loads data_byte_in and sets hold_valid.
  - ready_out = !hold_valid.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: tx_wire_out=1. If hold_valid, then:
    - load the shift register from hold_data;
    - clear hold_valid;
    - clear the bit counter and bit index;
    - go to START.
  - START: tx_wire_out=0 for UART_BIT_PERIOD cycles, then go to DATA.
  - DATA: tx_wire_out=shift[0]. At the end of each bit period, shift right and increment the 3-bit index. After bit 7, go to PARITY (if enabled) or STOP.
  - STOP: tx_wire_out=1 for UART_BIT_PERIOD cycles. At the end of the period:
    - if hold_valid, load the next byte and go directly to START (no idle gap);
    - otherwise go to IDLE.
- busy_out = (state != IDLE) || hold_valid.
- Load and accept on the same edge cannot happen: ready_out is low while hold_valid=1. After the FSM consumes the holding register, ready_out rises the next cycle.
- While ready_out=0, trigger_in and data_byte_in are ignored. There is no queueing beyond the single holding entry.

## Timing
- Reset values: tx_wire_out=1, ready_out=1, busy_out=0. Internally: hold_valid=0, state=IDLE, counters=0, shift=0.
- Reset mid-frame aborts the frame and discards any queued byte. tx_wire_out is 1 after the reset edge.
- Latency from an idle line:
  - accepting edge E0 sets hold_valid;
  - edge E0+1 enters START; tx_wire_out is low from E0+1.
- Every bit (start, data, parity, stop) lasts exactly UART_BIT_PERIOD cycles.
- Frame length: 10×UART_BIT_PERIOD cycles, or 11× with parity.
- Back-to-back: the next start bit begins on the cycle immediately following the last stop-bit cycle.
- ready_out deasserts the cycle after acceptance. It reasserts the cycle after the FSM loads from the holding register (entering START).
- busy_out falls on the edge that returns the FSM to IDLE with hold_valid=0.

## Configuration
- UART_TX_PARITY_EN defined:
  - adds the PARITY state after DATA;
  - for one bit period, tx_wire_out = ^byte (even parity: total ones in data+parity is even);
  - frame is 11 bits.
- UART_TX_PARITY_EN undefined:
  - no PARITY state, no parity logic;
  - DATA goes directly to STOP; frame is 10 bits.

## Test plan
All scenarios use INPUT_CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so UART_BIT_PERIOD=10.
- Reset: hold rst_in=1 for 3 cycles with trigger_in=1 -> tx_wire_out=1, ready_out=1, busy_out=0; nothing transmitted.
- Single byte: send 0xA5 at E0 -> after E0+1, tx_wire_out holds the following values for 10 cycles each:
  - start bit: 0;
  - data bits, LSB first: 1,0,1,0,0,1,0,1;
  - stop bit: 1.
  - busy_out=0 exactly 100 cycles after E0+1.
- Back-to-back: send 0x00, then 0xFF while the first frame is in DATA -> second start bit begins exactly 100 cycles after the first; line is high only during the 10-cycle stop bit between frames.
- Backpressure: hold trigger_in=1 with data_byte_in=0x11 while ready_out=0, then switch to 0x22 before ready_out rises -> only 0x22 appears in the second frame.
- Reset mid-frame: assert rst_in during data bit 3 of 0x3C with 0x55 queued -> tx_wire_out=1 the next cycle, ready_out=1; no further frames.
- Parity: send 0x07 -> with UART_TX_PARITY_EN, parity bit=1 and frame is 110 cycles; without it, frame is 100 cycles with the stop bit right after bit 7.
